// File: rtl/cmd_parse_ascii.sv
// Line-oriented ASCII command receiver: K/P load 128-bit key/plaintext from 32 hex digits,
// G/H set or clear the run level. Malformed or stalled commands are counted and dropped.
module cmd_parse_ascii #(
    parameter int unsigned TIMEOUT_COUNT = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   data,
    input  logic         valid,
    output logic         require,
    output logic [127:0] key,
    output logic [127:0] plain,
    output logic         key_load,
    output logic         plain_load,
    output logic         run,
    output logic         cmd_err,
    output logic [15:0]  err_count,
    output logic [2:0]   dbg_state
);

    localparam int unsigned TW = (TIMEOUT_COUNT > 2) ? $clog2(TIMEOUT_COUNT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_COUNT - 1);

    localparam logic [7:0] L_K = 8'h4B;
    localparam logic [7:0] L_P = 8'h50;
    localparam logic [7:0] L_G = 8'h47;
    localparam logic [7:0] L_H = 8'h48;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HEX       = 3'd1,
        S_WAIT_TERM = 3'd2,
        S_CTRL      = 3'd3,
        S_DISCARD   = 3'd4,
        S_COMMIT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_KEY   = 2'd0,
        CMD_PLAIN = 2'd1,
        CMD_GO    = 2'd2,
        CMD_HALT  = 2'd3
    } cmd_t;

    state_t         state_q;
    cmd_t           cmd_q;
    logic [127:0]   shift_q;
    logic [5:0]     cnt_q;
    logic [TW-1:0]  tmo_q;
    logic           require_q;
    logic [127:0]   key_q;
    logic [127:0]   plain_q;
    logic           key_load_q;
    logic           plain_load_q;
    logic           run_q;
    logic           cmd_err_q;
    logic [15:0]    err_q;

    // Handshake: a byte moves on a rising edge where valid && require are both high.
    logic       accept;
    logic       is_term;
    logic       is_space;
    logic [7:0] letter;
    logic       hex_ok;
    logic [3:0] hex_nib;
    logic       is_cmd;
    logic       tmo_fire;
    logic       in_cmd;
    logic       byte_err;
    logic       tmo_err;

    always_comb begin
        accept   = valid && require_q;
        is_term  = (data == 8'h0D) || (data == 8'h0A);
        is_space = (data == 8'h20);
        // Clearing bit 5 folds lower-case letters onto upper-case.
        letter   = {data[7:6], 1'b0, data[4:0]};
        hex_ok   = 1'b0;
        hex_nib  = 4'h0;
        if ((data >= 8'h30) && (data <= 8'h39)) begin
            hex_ok  = 1'b1;
            hex_nib = data[3:0];
        end else if ((letter >= 8'h41) && (letter <= 8'h46)) begin
            hex_ok  = 1'b1;
            hex_nib = data[3:0] + 4'd9;
        end
        is_cmd   = (letter == L_K) || (letter == L_P) || (letter == L_G) || (letter == L_H);
        tmo_fire = (tmo_q == TMO_LAST);
        in_cmd   = (state_q == S_HEX) || (state_q == S_WAIT_TERM) || (state_q == S_CTRL);
        byte_err = 1'b0;
        if (accept) begin
            unique case (state_q)
                S_IDLE:      byte_err = !is_term && !is_space && !is_cmd;
                S_HEX:       byte_err = !hex_ok;
                S_WAIT_TERM: byte_err = !is_term;
                S_CTRL:      byte_err = !is_term;
                default:     byte_err = 1'b0;
            endcase
        end
        tmo_err = !accept && tmo_fire && in_cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= CMD_KEY;
            shift_q      <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            require_q    <= 1'b0;
            key_q        <= '0;
            plain_q      <= '0;
            key_load_q   <= 1'b0;
            plain_load_q <= 1'b0;
            run_q        <= 1'b0;
            cmd_err_q    <= 1'b0;
            err_q        <= '0;
        end else begin
            require_q    <= 1'b1;
            key_load_q   <= 1'b0;
            plain_load_q <= 1'b0;
            cmd_err_q    <= byte_err || tmo_err;
            if ((byte_err || tmo_err) && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end

            if (accept || tmo_fire || (state_q == S_IDLE) || (state_q == S_COMMIT)) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end

            unique case (state_q)
                S_IDLE: begin
                    if (accept && !is_term && !is_space) begin
                        if ((letter == L_K) || (letter == L_P)) begin
                            shift_q <= '0;
                            cnt_q   <= '0;
                            cmd_q   <= (letter == L_K) ? CMD_KEY : CMD_PLAIN;
                            state_q <= S_HEX;
                        end else if ((letter == L_G) || (letter == L_H)) begin
                            cmd_q   <= (letter == L_G) ? CMD_GO : CMD_HALT;
                            state_q <= S_CTRL;
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end
                end
                S_HEX: begin
                    if (accept) begin
                        if (hex_ok) begin
                            shift_q <= {shift_q[123:0], hex_nib};
                            cnt_q   <= cnt_q + 6'd1;
                            if (cnt_q == 6'd31) begin
                                state_q <= S_WAIT_TERM;
                            end
                        end else if (is_term) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end else if (tmo_fire) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT_TERM: begin
                    if (accept) begin
                        if (is_term) begin
                            state_q   <= S_COMMIT;
                            require_q <= 1'b0;
                            if (cmd_q == CMD_KEY) begin
                                key_q      <= shift_q;
                                key_load_q <= 1'b1;
                            end else begin
                                plain_q      <= shift_q;
                                plain_load_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end else if (tmo_fire) begin
                        state_q <= S_IDLE;
                    end
                end
                S_CTRL: begin
                    if (accept) begin
                        if (is_term) begin
                            state_q   <= S_COMMIT;
                            require_q <= 1'b0;
                            run_q     <= (cmd_q == CMD_GO);
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end else if (tmo_fire) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if ((accept && is_term) || (!accept && tmo_fire)) begin
                        state_q <= S_IDLE;
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign require    = require_q;
    assign key        = key_q;
    assign plain      = plain_q;
    assign key_load   = key_load_q;
    assign plain_load = plain_load_q;
    assign run        = run_q;
    assign cmd_err    = cmd_err_q;
    assign err_count  = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cmd_parse_ascii.sv
// Scoreboard bench for cmd_parse_ascii: drivers push expected commits/errors, a negedge
// monitor pops and compares whenever a load pulse, run change or error pulse appears.
module tb_cmd_parse_ascii;

  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   data;
  logic         valid;
  logic         require;
  logic [127:0] key;
  logic [127:0] plain;
  logic         key_load;
  logic         plain_load;
  logic         run;
  logic         cmd_err;
  logic [15:0]  err_count;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  cmd_parse_ascii #(.TIMEOUT_COUNT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .valid      (valid),
    .require    (require),
    .key        (key),
    .plain      (plain),
    .key_load   (key_load),
    .plain_load (plain_load),
    .run        (run),
    .cmd_err    (cmd_err),
    .err_count  (err_count),
    .dbg_state  (dbg_state)
  );

  int tests = 0;
  int failed = 0;

  logic [127:0] exp_key_q[$];
  logic [127:0] exp_plain_q[$];
  logic         exp_run_q[$];
  logic [15:0]  exp_err_q[$];

  logic [127:0] m_key = '0;
  logic [127:0] m_plain = '0;
  logic         m_run = 1'b0;
  logic         prev_run = 1'b0;
  int           stall = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    failed++;
    $display("FAIL %s: event seen with no expected entry queued", name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_run = run;
      stall = 0;
    end else begin
      if (!require) begin
        stall++;
        if (stall > 1) begin
          tests++;
          failed++;
          $display("FAIL require_stall: low for %0d cycles, expected at most 1", stall);
        end
      end else begin
        stall = 0;
      end

      if (key_load) begin
        check("commit_require_key", require, 1'b0);
        if (exp_key_q.size() == 0) unexpected("key_load");
        else begin
          m_key = exp_key_q.pop_front();
          check("key", key, m_key);
        end
        check("plain_hold_on_key", plain, m_plain);
      end

      if (plain_load) begin
        check("commit_require_plain", require, 1'b0);
        if (exp_plain_q.size() == 0) unexpected("plain_load");
        else begin
          m_plain = exp_plain_q.pop_front();
          check("plain", plain, m_plain);
        end
        check("key_hold_on_plain", key, m_key);
      end

      if (run !== prev_run) begin
        if (exp_run_q.size() == 0) unexpected("run_change");
        else begin
          m_run = exp_run_q.pop_front();
          check("run", run, m_run);
        end
        prev_run = run;
      end

      if (cmd_err) begin
        if (exp_err_q.size() == 0) unexpected("cmd_err");
        else check("err_count", err_count, exp_err_q.pop_front());
        check("key_hold_on_err", key, m_key);
        check("plain_hold_on_err", plain, m_plain);
        check("run_hold_on_err", run, m_run);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    logic ok;
    n = 0;
    data = b;
    valid = 1'b1;
    forever begin
      ok = require;
      @(negedge clk);
      if (ok) break;
      n++;
      if (n > 50) begin
        tests++;
        failed++;
        $display("FAIL send_timeout: byte %h not accepted, require low for %0d cycles", b, n);
        break;
      end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    data = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    check({name, "_key_q"}, exp_key_q.size(), 0);
    check({name, "_plain_q"}, exp_plain_q.size(), 0);
    check({name, "_run_q"}, exp_run_q.size(), 0);
    check({name, "_err_q"}, exp_err_q.size(), 0);
  endtask

  task automatic clear_model();
    m_key = '0;
    m_plain = '0;
    m_run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_key", key, '0);
    check("rst_plain", plain, '0);
    check("rst_run", run, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    check("rst_require", require, 1'b0);
    check("rst_key_load", key_load, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_require", require, 1'b1);
    check("post_rst_state", dbg_state, 3'd0);

    // Test 1: key load, valid held through terminator
    exp_key_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
    send_str("K000102030405060708090A0B0C0D0E0F");
    send_byte(8'h0D);
    check("t1_key_load", key_load, 1'b1);
    check("t1_require_low", require, 1'b0);
    check("t1_key_value", key, 128'h000102030405060708090A0B0C0D0E0F);
    @(negedge clk);
    check("t1_require_back", require, 1'b1);
    check("t1_key_load_single", key_load, 1'b0);
    idle(3);

    // Test 2: plaintext, lower-case command and digits
    exp_plain_q.push_back(128'h00112233445566778899AABBCCDDEEFF);
    send_str("p00112233445566778899aabbccddeeff");
    send_byte(8'h0A);
    idle(3);
    check("t2_plain_value", plain, 128'h00112233445566778899AABBCCDDEEFF);

    // Test 3: bad digit, discard, then G / h
    exp_err_q.push_back(16'd1);
    send_str("K12Z4");
    send_byte(8'h0D);
    idle(3);
    check("t3_key_unchanged", key, 128'h000102030405060708090A0B0C0D0E0F);
    exp_run_q.push_back(1'b1);
    send_str("G");
    send_byte(8'h0D);
    idle(3);
    check("t3_run_set", run, 1'b1);
    exp_run_q.push_back(1'b0);
    send_str("h");
    send_byte(8'h0D);
    idle(3);
    check("t3_run_clear", run, 1'b0);

    check_drained("pre_rst1");
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 4: short and long hex payloads, then a good command
    exp_err_q.push_back(16'd1);
    send_str("K1234");
    send_byte(8'h0D);
    exp_err_q.push_back(16'd2);
    send_byte("P");
    repeat (33) send_byte("1");
    send_byte(8'h0D);
    idle(3);
    check("t4_err_count", err_count, 16'd2);
    check("t4_key_unchanged", key, '0);
    check("t4_plain_unchanged", plain, '0);
    exp_plain_q.push_back(128'hFEDCBA9876543210FEDCBA9876543210);
    send_str("PFEDCBA9876543210fedcba9876543210");
    send_byte(8'h0D);
    idle(3);
    check("t4_plain_value", plain, 128'hFEDCBA9876543210FEDCBA9876543210);

    // Test 5: timeout inside a command, silent timeout in discard
    exp_err_q.push_back(16'd3);
    send_str("K12");
    idle(TMO + 10);
    check("t5_state_idle_after_tmo", dbg_state, 3'd0);
    check("t5_err_count_tmo", err_count, 16'd3);
    exp_run_q.push_back(1'b1);
    send_str("G");
    send_byte(8'h0D);
    idle(3);
    check("t5_run_set", run, 1'b1);
    exp_err_q.push_back(16'd4);
    send_str("X");
    idle(TMO + 10);
    check("t5_state_idle_after_discard", dbg_state, 3'd0);
    check("t5_err_count_x", err_count, 16'd4);

    // Test 6: asynchronous reset mid-command
    check_drained("pre_rst2");
    send_str("K0011");
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    check("t6_async_run", run, 1'b0);
    check("t6_async_plain", plain, '0);
    check("t6_async_key", key, '0);
    check("t6_async_err_count", err_count, 16'd0);
    check("t6_async_require", require, 1'b0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_key_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
    send_str("K000102030405060708090A0B0C0D0E0F");
    send_byte(8'h0D);
    idle(3);
    check("t6_key_value", key, 128'h000102030405060708090A0B0C0D0E0F);
    check("t6_run_still_low", run, 1'b0);

    idle(5);
    check_drained("final");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
